// File: rtl/dm_ctrl.sv
// Data-memory controller: multi-cycle byte/half/word load-store into an internal word array.
// Latency: request accepted in IDLE at cycle N, done/err/rdata presented at cycle N+WAIT_STATES+1.
// Backpressure: stall = req & ~done holds the pipeline; inputs are captured at acceptance.
// Ports: clk, rstn (async active-low); req/we/addr/wdata/dmtype from the MEM stage;
//        rdata/done/err registered completion outputs (zero outside ACK);
//        stall combinational; acc_cnt counts completed accesses and wraps.
module dm_ctrl #(
   parameter int DEPTH_WORDS = 128,
   parameter int WAIT_STATES = 1,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 req,
   input  logic                 we,
   input  logic [31:0]          addr,
   input  logic [31:0]          wdata,
   input  logic [2:0]           dmtype,
   output logic [31:0]          rdata,
   output logic                 stall,
   output logic                 done,
   output logic                 err,
   output logic [CNT_WIDTH-1:0] acc_cnt
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

   localparam logic [2:0] T_W  = 3'd0;
   localparam logic [2:0] T_H  = 3'd1;
   localparam logic [2:0] T_HU = 3'd2;
   localparam logic [2:0] T_B  = 3'd3;
   localparam logic [2:0] T_BU = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t      state, state_nxt;
   logic [3:0]  wcnt, wcnt_nxt;
   logic        go_ack;

   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  type_q;

   logic        op_we;
   logic [31:0] op_addr;
   logic [31:0] op_wdata;
   logic [2:0]  op_type;

   logic [AW-1:0] idx;
   logic        oor, bad_align, bad_type, acc_err;
   logic [31:0] cur_word, load_val, wr_word;
   logic [15:0] sel_h;
   logic [7:0]  sel_b;
   logic        mem_wr;

   logic [31:0] mem [DEPTH_WORDS];

   assign stall = req & ~done;

   // With zero wait states the access completes on the acceptance edge, so the
   // operands must come straight from the inputs while still in IDLE.
   always_comb begin
      if (state == S_IDLE) begin
         op_we    = we;
         op_addr  = addr;
         op_wdata = wdata;
         op_type  = dmtype;
      end else begin
         op_we    = we_q;
         op_addr  = addr_q;
         op_wdata = wdata_q;
         op_type  = type_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
         wcnt  <= 4'd0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      go_ack    = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               wcnt_nxt = 4'd0;
               if (WAIT_STATES == 0) begin
                  state_nxt = S_ACK;
                  go_ack    = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (wcnt == WS_LAST) begin
               state_nxt = S_ACK;
               wcnt_nxt  = 4'd0;
               go_ack    = 1'b1;
            end else begin
               wcnt_nxt = wcnt + 4'd1;
            end
         end
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         type_q  <= 3'd0;
      end else if (state == S_IDLE && req) begin
         we_q    <= we;
         addr_q  <= addr;
         wdata_q <= wdata;
         type_q  <= dmtype;
      end
   end

   // Address decode and error classification
   assign idx = op_addr[AW+1:2];
   assign oor = (op_addr >> (AW + 2)) != 32'd0;

   always_comb begin
      bad_align = 1'b0;
      bad_type  = 1'b0;
      case (op_type)
         T_W:        bad_align = op_addr[1:0] != 2'b00;
         T_H, T_HU:  bad_align = op_addr[0];
         T_B, T_BU:  bad_align = 1'b0;
         default:    bad_type  = 1'b1;
      endcase
   end

   assign acc_err  = oor | bad_align | bad_type;
   assign cur_word = mem[idx];
   assign sel_h    = op_addr[1] ? cur_word[31:16] : cur_word[15:0];

   always_comb begin
      case (op_addr[1:0])
         2'd0:    sel_b = cur_word[7:0];
         2'd1:    sel_b = cur_word[15:8];
         2'd2:    sel_b = cur_word[23:16];
         default: sel_b = cur_word[31:24];
      endcase
   end

   always_comb begin
      case (op_type)
         T_W:     load_val = cur_word;
         T_H:     load_val = {{16{sel_h[15]}}, sel_h};
         T_HU:    load_val = {16'd0, sel_h};
         T_B:     load_val = {{24{sel_b[7]}}, sel_b};
         T_BU:    load_val = {24'd0, sel_b};
         default: load_val = 32'd0;
      endcase
   end

   // Read-modify-write merge: only the addressed lanes change
   always_comb begin
      wr_word = cur_word;
      case (op_type)
         T_W: wr_word = op_wdata;
         T_H, T_HU: begin
            if (op_addr[1]) wr_word[31:16] = op_wdata[15:0];
            else            wr_word[15:0]  = op_wdata[15:0];
         end
         T_B, T_BU: begin
            case (op_addr[1:0])
               2'd0:    wr_word[7:0]   = op_wdata[7:0];
               2'd1:    wr_word[15:8]  = op_wdata[7:0];
               2'd2:    wr_word[23:16] = op_wdata[7:0];
               default: wr_word[31:24] = op_wdata[7:0];
            endcase
         end
         default: wr_word = cur_word;
      endcase
   end

   // rstn gates the write so an access racing reset never lands in the array
   assign mem_wr = go_ack & op_we & ~acc_err & rstn;

   always_ff @(posedge clk) begin
      if (mem_wr) mem[idx] <= wr_word;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         done    <= 1'b0;
         err     <= 1'b0;
         rdata   <= 32'd0;
         acc_cnt <= '0;
      end else if (go_ack) begin
         done    <= 1'b1;
         err     <= acc_err;
         rdata   <= (acc_err | op_we) ? 32'd0 : load_val;
         acc_cnt <= acc_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         done  <= 1'b0;
         err   <= 1'b0;
         rdata <= 32'd0;
      end
   end

endmodule
